vdp_super_vram_arbiter: RTL and testbench
=========================================

Name: vdp_super_vram_arbiter

Overview:
- Slot-based scheduler for the single 32-bit VRAM port shared by the super-res display fetch, the CPU port and the command engine.
- Divides each line into 4-clock slots aligned to cx[1:0]. Each slot goes to exactly one owner: display, refresh, CPU or command.
- Display owns every slot while the super-res bus-arbitration window is open. All other slots go round-robin to CPU and command requesters through a req/ack handshake.

Parameters:
- ADDR_W, 18, VRAM byte-address width.
- REFRESH_X, 720, cx value that starts the per-line refresh slot; must satisfy REFRESH_X[1:0]==0.
- CMD_FIRST, 0, when 1 the command engine wins the first contested slot after reset.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- vdp_super  in  1  super-res mode enable
- super_res_drawing  in  1  display bus window open
- cx  in  10  horizontal pixel counter
- disp_addr  in  ADDR_W  display fetch address
- cpu_req  in  1  CPU access request
- cpu_we  in  1  CPU write
- cpu_addr  in  ADDR_W  CPU byte address
- cpu_wdata  in  8  CPU write byte
- cpu_ack  out  1  CPU access complete, one-clock pulse
- cpu_rdata  out  8  CPU read byte
- cmd_req  in  1  command request
- cmd_we  in  1  command write
- cmd_addr  in  ADDR_W  command address, bits [1:0] ignored
- cmd_wdata  in  32  command write word
- cmd_be  in  4  command byte enables
- cmd_ack  out  1  command complete, one-clock pulse
- cmd_rdata  out  32  command read word
- vram_addr  out  ADDR_W  VRAM address
- vram_we  out  1  VRAM write strobe
- vram_be  out  4  VRAM byte enables
- vram_wdata  out  32  VRAM write data
- vram_refresh  out  1  refresh strobe
- vram_rdata  in  32  VRAM read data
- owner  out  2  current slot owner: 0 idle, 1 display, 2 CPU, 3 command

Behaviour:
- Reset: every output 0; round-robin pointer set from CMD_FIRST; any in-flight access is abandoned and its ack is never issued.
- Slot start is any clock with cx[1:0]==0. Owner is decided on that edge, in priority order:
  - refresh, if cx==REFRESH_X;
  - display, if vdp_super && super_res_drawing;
  - otherwise round-robin between pending cpu_req and cmd_req;
  - otherwise idle.
- Owner is held through cx[1:0]==3.
- Display slot: vram_addr<=disp_addr, vram_we=0.
- Refresh slot: vram_refresh pulses high for the first clock of the slot.
- CPU slot:
  - vram_addr<=cpu_addr; vram_be one-hot from cpu_addr[1:0]; vram_wdata = cpu_wdata replicated to all four bytes.
  - For writes, vram_we is high for the first slot clock only.
- Command slot: cmd_addr, cmd_be and cmd_wdata are driven the same way, with cmd_addr[1:0] forced to 0.
- Read capture:
  - vram_rdata is captured on the edge where cx[1:0]==2.
  - cpu_rdata takes the byte selected by cpu_addr[1:0]; cmd_rdata takes the full word.
  - The matching ack pulses during cx[1:0]==3, so the latency is 3 clocks from slot start. Writes ack at the same point.
- Round-robin: the pointer toggles only when a contested grant occurs. A lone requester always wins.
- Handshake:
  - req must stay high until ack; address and data are sampled at grant.
  - Req dropped before grant withdraws the request.
  - Req dropped after grant: the access completes and ack still pulses.
  - A requester may re-assert req in the cycle after ack.
- vdp_super=0: display never owns a slot; refresh still happens.
- super_res_drawing changing mid-slot has no effect until the next slot start.

Optional Feature:
- Macro: VDP_ARB_PERF_COUNTERS_EN.
- When defined, adds outputs perf_disp, perf_cpu, perf_cmd and perf_idle, each 16 bits. Each counts slots granted to that owner, saturates at 0xFFFF, and clears on reset or at the slot start where cx==REFRESH_X.
- When undefined, these ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package (vdp_arb_pkg): owner enum (OWN_IDLE, OWN_DISP, OWN_CPU, OWN_CMD), SLOT_PHASE constants (0..3), and a function mapping a byte lane to a one-hot be.
- One natural sub-module, vdp_arb_rr2: a two-requester round-robin picker holding the pointer.

Test Plan:
- cpu_req write, addr 0x00102, data 0x5A, vdp_super=0 -> vram_be=4'b0100, vram_wdata=0x5A5A5A5A, vram_we high 1 clock, cpu_ack 3 clocks after slot start.
- super_res_drawing=1, cpu_req held -> owner=1 for every slot and no cpu_ack; drawing drops at cx=700 -> CPU granted at cx=700, ack at cx=703.
- cpu_req and cmd_req both held, CMD_FIRST=0 -> grants alternate CPU, CMD, CPU, CMD in consecutive slots.
- cx=720 with cmd_req pending -> vram_refresh pulses, cmd granted at cx=724.
- cmd read, vram_rdata=0xDEADBEEF at phase 2 -> cmd_rdata=0xDEADBEEF with cmd_ack at phase 3.
- reset asserted at phase 1 of a CPU slot -> cpu_ack never pulses, all outputs 0 on the next clock.

Source files
------------

// File: rtl/vdp_arb_pkg.sv
// Shared types and helpers for the super-res VRAM slot arbiter.
// Owner encoding, slot phase constants, bus payload struct and lane helpers.
package vdp_arb_pkg;

  localparam int unsigned CX_W = 10;

  typedef enum logic [1:0] {
    OWN_IDLE = 2'd0,
    OWN_DISP = 2'd1,
    OWN_CPU  = 2'd2,
    OWN_CMD  = 2'd3
  } owner_t;

  localparam logic [1:0] SLOT_PHASE_0 = 2'd0;
  localparam logic [1:0] SLOT_PHASE_1 = 2'd1;
  localparam logic [1:0] SLOT_PHASE_2 = 2'd2;
  localparam logic [1:0] SLOT_PHASE_3 = 2'd3;

  // Write-side payload launched at slot start.
  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } vram_wr_t;

  function automatic logic [3:0] lane_be(input logic [1:0] lane);
    return 4'b0001 << lane;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/vdp_arb_rr2.sv
// Two-requester round-robin picker (CPU vs command) owning the preference pointer.
// The pointer only moves when both requesters contend in an arbitrated slot.
module vdp_arb_rr2 #(
  parameter bit CMD_FIRST = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic advance,
  input  logic req_cpu,
  input  logic req_cmd,
  output logic grant_cpu_c,
  output logic grant_cmd_c
);

  logic prefer_cmd;
  logic contested;

  assign contested   = req_cpu && req_cmd;
  assign grant_cpu_c = advance && req_cpu && !(contested && prefer_cmd);
  assign grant_cmd_c = advance && req_cmd && !(contested && !prefer_cmd);

  always_ff @(posedge clk) begin
    if (reset) begin
      prefer_cmd <= CMD_FIRST;
    end else if (advance && contested) begin
      prefer_cmd <= !prefer_cmd;
    end
  end

endmodule

// File: rtl/vdp_super_vram_arbiter.sv
// Slot scheduler for the shared 32-bit VRAM port: refresh, display, CPU, command.
// Optional slot counters enabled by defining VDP_ARB_PERF_COUNTERS_EN.
module vdp_super_vram_arbiter
  import vdp_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = 18,
  parameter int unsigned REFRESH_X = 720,
  parameter bit          CMD_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vdp_super,
  input  logic              super_res_drawing,
  input  logic [CX_W-1:0]   cx,
  input  logic [ADDR_W-1:0] disp_addr,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic              cpu_ack,
  output logic [7:0]        cpu_rdata,
  input  logic              cmd_req,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [31:0]       cmd_wdata,
  input  logic [3:0]        cmd_be,
  output logic              cmd_ack,
  output logic [31:0]       cmd_rdata,
  output logic [ADDR_W-1:0] vram_addr,
  output logic              vram_we,
  output logic [3:0]        vram_be,
  output logic [31:0]       vram_wdata,
  output logic              vram_refresh,
  input  logic [31:0]       vram_rdata,
`ifdef VDP_ARB_PERF_COUNTERS_EN
  output logic [15:0]       perf_disp,
  output logic [15:0]       perf_cpu,
  output logic [15:0]       perf_cmd,
  output logic [15:0]       perf_idle,
`endif
  output logic [1:0]        owner
);

  localparam logic [CX_W-1:0] REFRESH_CX = CX_W'(REFRESH_X);

  logic [1:0]        phase;
  logic              slot_start;
  logic              refresh_slot;
  logic              disp_slot;
  logic              arb_slot;
  logic              grant_cpu_c;
  logic              grant_cmd_c;
  owner_t            owner_q;
  owner_t            next_owner;
  logic [ADDR_W-1:0] next_addr;
  vram_wr_t          next_wr;
  logic              wr_q;
  logic [7:0]        rd_byte;

  assign phase        = cx[1:0];
  assign slot_start   = (phase == SLOT_PHASE_0);
  assign refresh_slot = (cx == REFRESH_CX);
  assign disp_slot    = vdp_super && super_res_drawing;
  assign arb_slot     = slot_start && !refresh_slot && !disp_slot;
  assign owner        = owner_q;

  // Byte lane of the CPU access is still held on vram_addr at capture time.
  assign rd_byte = vram_rdata[{vram_addr[1:0], 3'b000} +: 8];

  vdp_arb_rr2 #(
    .CMD_FIRST (CMD_FIRST)
  ) u_rr2 (
    .clk         (clk),
    .reset       (reset),
    .advance     (arb_slot),
    .req_cpu     (cpu_req),
    .req_cmd     (cmd_req),
    .grant_cpu_c (grant_cpu_c),
    .grant_cmd_c (grant_cmd_c)
  );

  // Slot owner and bus payload, valid on slot-start clocks.
  always_comb begin
    next_owner = OWN_IDLE;
    next_addr  = '0;
    next_wr    = '0;
    if (!refresh_slot) begin
      if (disp_slot) begin
        next_owner = OWN_DISP;
        next_addr  = disp_addr;
      end else if (grant_cpu_c) begin
        next_owner    = OWN_CPU;
        next_addr     = cpu_addr;
        next_wr.we    = cpu_we;
        next_wr.be    = lane_be(cpu_addr[1:0]);
        next_wr.wdata = {4{cpu_wdata}};
      end else if (grant_cmd_c) begin
        next_owner    = OWN_CMD;
        next_addr     = cmd_addr & ~ADDR_W'(2'b11);
        next_wr.we    = cmd_we;
        next_wr.be    = cmd_be;
        next_wr.wdata = cmd_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q      <= OWN_IDLE;
      wr_q         <= 1'b0;
      vram_addr    <= '0;
      vram_we      <= 1'b0;
      vram_be      <= '0;
      vram_wdata   <= '0;
      vram_refresh <= 1'b0;
      cpu_ack      <= 1'b0;
      cpu_rdata    <= '0;
      cmd_ack      <= 1'b0;
      cmd_rdata    <= '0;
    end else begin
      vram_we      <= 1'b0;
      vram_refresh <= 1'b0;
      cpu_ack      <= 1'b0;
      cmd_ack      <= 1'b0;
      case (phase)
        SLOT_PHASE_0: begin
          owner_q      <= next_owner;
          wr_q         <= next_wr.we;
          vram_addr    <= next_addr;
          vram_we      <= next_wr.we;
          vram_be      <= next_wr.be;
          vram_wdata   <= next_wr.wdata;
          vram_refresh <= refresh_slot;
        end
        // Read data lands here; ack shows in the last slot clock.
        SLOT_PHASE_2: begin
          if (owner_q == OWN_CPU) begin
            cpu_ack <= 1'b1;
            if (!wr_q) cpu_rdata <= rd_byte;
          end
          if (owner_q == OWN_CMD) begin
            cmd_ack <= 1'b1;
            if (!wr_q) cmd_rdata <= vram_rdata;
          end
        end
        SLOT_PHASE_1, SLOT_PHASE_3: begin
        end
      endcase
    end
  end

`ifdef VDP_ARB_PERF_COUNTERS_EN
  // Per-owner slot counts, restarted at each line's refresh slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_disp <= '0;
      perf_cpu  <= '0;
      perf_cmd  <= '0;
      perf_idle <= '0;
    end else if (slot_start) begin
      if (refresh_slot) begin
        perf_disp <= '0;
        perf_cpu  <= '0;
        perf_cmd  <= '0;
        perf_idle <= '0;
      end else begin
        case (next_owner)
          OWN_DISP: perf_disp <= sat_inc(perf_disp);
          OWN_CPU:  perf_cpu  <= sat_inc(perf_cpu);
          OWN_CMD:  perf_cmd  <= sat_inc(perf_cmd);
          OWN_IDLE: perf_idle <= sat_inc(perf_idle);
        endcase
      end
    end
  end
`endif

endmodule

// File: tb/tb_vdp_super_vram_arbiter.sv
// Bench for vdp_super_vram_arbiter: slot-level reference model plus directed
// scenarios, then randomized requesters, display window and resets.
module tb_vdp_super_vram_arbiter;

  localparam int unsigned ADDR_W    = 18;
  localparam int unsigned REFRESH_X = 720;
  localparam int unsigned LINE      = 856;
  localparam bit          CMD_FIRST = 1'b0;

  logic              clk = 1'b0;
  logic              reset;
  logic              vdp_super;
  logic              super_res_drawing;
  logic [9:0]        cx;
  logic [ADDR_W-1:0] disp_addr;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [7:0]        cpu_wdata;
  logic              cpu_ack;
  logic [7:0]        cpu_rdata;
  logic              cmd_req;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [31:0]       cmd_wdata;
  logic [3:0]        cmd_be;
  logic              cmd_ack;
  logic [31:0]       cmd_rdata;
  logic [ADDR_W-1:0] vram_addr;
  logic              vram_we;
  logic [3:0]        vram_be;
  logic [31:0]       vram_wdata;
  logic              vram_refresh;
  logic [31:0]       vram_rdata;
  logic [1:0]        owner;

  vdp_super_vram_arbiter #(
    .ADDR_W    (ADDR_W),
    .REFRESH_X (REFRESH_X),
    .CMD_FIRST (CMD_FIRST)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .vdp_super         (vdp_super),
    .super_res_drawing (super_res_drawing),
    .cx                (cx),
    .disp_addr         (disp_addr),
    .cpu_req           (cpu_req),
    .cpu_we            (cpu_we),
    .cpu_addr          (cpu_addr),
    .cpu_wdata         (cpu_wdata),
    .cpu_ack           (cpu_ack),
    .cpu_rdata         (cpu_rdata),
    .cmd_req           (cmd_req),
    .cmd_we            (cmd_we),
    .cmd_addr          (cmd_addr),
    .cmd_wdata         (cmd_wdata),
    .cmd_be            (cmd_be),
    .cmd_ack           (cmd_ack),
    .cmd_rdata         (cmd_rdata),
    .vram_addr         (vram_addr),
    .vram_we           (vram_we),
    .vram_be           (vram_be),
    .vram_wdata        (vram_wdata),
    .vram_refresh      (vram_refresh),
    .vram_rdata        (vram_rdata),
    .owner             (owner)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit run   = 1'b0;

  // Expected outputs as seen after each edge.
  int                m_owner;
  logic [ADDR_W-1:0] m_addr;
  logic [3:0]        m_be;
  logic [31:0]       m_wdata;
  bit                m_we, m_refresh, m_cpu_ack, m_cmd_ack, m_slot_rd;
  logic [7:0]        m_cpu_rdata;
  logic [31:0]       m_cmd_rdata;
  bit                chk_addr, chk_bewd, chk_rd_cpu, chk_rd_cmd;
  bit                pref_cmd;
  int                cpu_st, cmd_st;  // 0 idle, 1 waiting, 2 granted
  int                rst_hold = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cx=%0d t=%0t)", nm, act, exp, cx, $time);
    end
  endfunction

  // Slot rules applied to the inputs sampled at this edge.
  task automatic model_edge();
    int who;
    m_we = 0; m_refresh = 0; m_cpu_ack = 0; m_cmd_ack = 0;
    chk_rd_cpu = 0; chk_rd_cmd = 0;
    if (reset) begin
      m_owner = 0; m_addr = '0; m_be = '0; m_wdata = '0;
      m_cpu_rdata = '0; m_cmd_rdata = '0; m_slot_rd = 0;
      pref_cmd = CMD_FIRST;
      chk_addr = 1; chk_bewd = 1; chk_rd_cpu = 1; chk_rd_cmd = 1;
      cpu_st = 0; cmd_st = 0;
    end else if (cx % 4 == 0) begin
      who = 0;
      if (cx == REFRESH_X) m_refresh = 1;
      else if (vdp_super && super_res_drawing) who = 1;
      else if (cpu_req && cmd_req) begin
        who = pref_cmd ? 3 : 2;
        pref_cmd = !pref_cmd;
      end else if (cpu_req) who = 2;
      else if (cmd_req) who = 3;
      m_owner = who;
      chk_addr = (who != 0);
      chk_bewd = (who >= 2);
      m_slot_rd = 0;
      case (who)
        1: m_addr = disp_addr;
        2: begin
          m_addr = cpu_addr;
          m_be = 4'(32'd1 << (cpu_addr % 4));
          m_wdata = {4{cpu_wdata}};
          m_we = cpu_we; m_slot_rd = !cpu_we; cpu_st = 2;
        end
        3: begin
          m_addr = cmd_addr - (cmd_addr % 4);
          m_be = cmd_be; m_wdata = cmd_wdata;
          m_we = cmd_we; m_slot_rd = !cmd_we; cmd_st = 2;
        end
        default: ;
      endcase
    end else if (cx % 4 == 2) begin
      if (m_owner == 2) begin
        m_cpu_ack = 1; cpu_st = 0;
        if (m_slot_rd) begin
          m_cpu_rdata = 8'(vram_rdata >> (8 * (m_addr % 4)));
          chk_rd_cpu = 1;
        end
      end
      if (m_owner == 3) begin
        m_cmd_ack = 1; cmd_st = 0;
        if (m_slot_rd) begin
          m_cmd_rdata = vram_rdata;
          chk_rd_cmd = 1;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    cx = (cx == 10'(LINE - 1)) ? 10'd0 : cx + 10'd1;
  endtask

  task automatic run_to(input int target);
    int n = 0;
    while (cx != 10'(target) && n < 2 * LINE) begin
      tick();
      n++;
    end
    chk("run_to", 32'(cx), 32'(target));
  endtask

  always @(negedge clk) begin
    if (run) begin
      chk("owner", 32'(owner), 32'(m_owner));
      chk("vram_we", 32'(vram_we), 32'(m_we));
      chk("vram_refresh", 32'(vram_refresh), 32'(m_refresh));
      chk("cpu_ack", 32'(cpu_ack), 32'(m_cpu_ack));
      chk("cmd_ack", 32'(cmd_ack), 32'(m_cmd_ack));
      if (chk_addr) chk("vram_addr", 32'(vram_addr), 32'(m_addr));
      if (chk_bewd) begin
        chk("vram_be", 32'(vram_be), 32'(m_be));
        chk("vram_wdata", vram_wdata, m_wdata);
      end
      if (chk_rd_cpu) chk("cpu_rdata", 32'(cpu_rdata), 32'(m_cpu_rdata));
      if (chk_rd_cmd) chk("cmd_rdata", cmd_rdata, m_cmd_rdata);
    end
  end

  task automatic rand_drive();
    vram_rdata = $urandom;
    disp_addr  = ADDR_W'($urandom);
    if ($urandom_range(199, 0) == 0) vdp_super = !vdp_super;
    if ($urandom_range(29, 0) == 0) super_res_drawing = !super_res_drawing;
    if (rst_hold > 0) rst_hold--;
    reset = (rst_hold > 0);
    if (!reset && $urandom_range(1499, 0) == 0) begin
      reset = 1'b1;
      rst_hold = 3;
    end
    case (cpu_st)
      0: if (!reset && $urandom_range(2, 0) == 0) begin
        cpu_req = 1'b1; cpu_we = 1'($urandom);
        cpu_addr = ADDR_W'($urandom); cpu_wdata = 8'($urandom); cpu_st = 1;
      end else cpu_req = 1'b0;
      1: if ($urandom_range(39, 0) == 0) begin cpu_req = 1'b0; cpu_st = 0; end
      default: if ($urandom_range(3, 0) == 0) begin
        cpu_req = 1'b0; cpu_addr = ADDR_W'($urandom); cpu_wdata = 8'($urandom);
      end
    endcase
    case (cmd_st)
      0: if (!reset && $urandom_range(2, 0) == 0) begin
        cmd_req = 1'b1; cmd_we = 1'($urandom); cmd_addr = ADDR_W'($urandom);
        cmd_wdata = $urandom; cmd_be = 4'($urandom); cmd_st = 1;
      end else cmd_req = 1'b0;
      1: if ($urandom_range(39, 0) == 0) begin cmd_req = 1'b0; cmd_st = 0; end
      default: if ($urandom_range(3, 0) == 0) begin
        cmd_req = 1'b0; cmd_addr = ADDR_W'($urandom); cmd_wdata = $urandom;
      end
    endcase
  endtask

  initial begin
    reset = 1'b1; vdp_super = 1'b0; super_res_drawing = 1'b0; cx = '0;
    disp_addr = '0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    cmd_req = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_be = '0;
    vram_rdata = '0;
    tick();
    run = 1'b1;
    tick(); tick();
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_vram_addr", 32'(vram_addr), 32'd0);
    chk("rst_vram_be", 32'(vram_be), 32'd0);
    chk("rst_cpu_ack", 32'(cpu_ack), 32'd0);
    reset = 1'b0;

    // CPU write, lane 2
    run_to(100);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 18'h00102; cpu_wdata = 8'h5A;
    tick();
    chk("t1_owner", 32'(owner), 32'd2);
    chk("t1_be", 32'(vram_be), 32'h4);
    chk("t1_wdata", vram_wdata, 32'h5A5A5A5A);
    chk("t1_addr", 32'(vram_addr), 32'h00102);
    chk("t1_we_first", 32'(vram_we), 32'd1);
    tick();
    chk("t1_we_second", 32'(vram_we), 32'd0);
    tick();
    chk("t1_ack", 32'(cpu_ack), 32'd1);
    cpu_req = 1'b0;
    tick();
    chk("t1_ack_pulse", 32'(cpu_ack), 32'd0);

    // Display window blocks a held CPU read until it closes at cx=700
    run_to(680);
    vdp_super = 1'b1; super_res_drawing = 1'b1; vram_rdata = 32'h11223344;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 18'h30001;
    for (int n = 0; n < 40 && cx != 10'd700; n++) begin
      tick();
      chk("t2_no_ack", 32'(cpu_ack), 32'd0);
      if (cx % 4 == 1) chk("t2_disp_owner", 32'(owner), 32'd1);
    end
    super_res_drawing = 1'b0;
    tick();
    chk("t2_cpu_owner", 32'(owner), 32'd2);
    chk("t2_be", 32'(vram_be), 32'h2);
    tick(); tick();
    chk("t2_cx", 32'(cx), 32'd703);
    chk("t2_ack", 32'(cpu_ack), 32'd1);
    chk("t2_rdata", 32'(cpu_rdata), 32'h33);
    cpu_req = 1'b0;

    // Refresh at 720 defers a pending command read to 724
    run_to(717);
    cmd_req = 1'b1; cmd_we = 1'b0; cmd_addr = 18'h20407; cmd_be = 4'hF;
    run_to(720);
    tick();
    chk("t4_refresh", 32'(vram_refresh), 32'd1);
    chk("t4_owner", 32'(owner), 32'd0);
    tick();
    chk("t4_refresh_pulse", 32'(vram_refresh), 32'd0);
    run_to(724);
    tick();
    chk("t4_cmd_owner", 32'(owner), 32'd3);
    chk("t4_cmd_addr", 32'(vram_addr), 32'h20404);
    tick();
    vram_rdata = 32'hDEADBEEF;
    tick();
    chk("t5_ack", 32'(cmd_ack), 32'd1);
    chk("t5_rdata", cmd_rdata, 32'hDEADBEEF);

    // Contested requests alternate CPU, CMD, CPU, CMD
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 18'h00003; cpu_wdata = 8'hC3;
    cmd_req = 1'b1; cmd_we = 1'b1; cmd_addr = 18'h00010; cmd_be = 4'b1001; cmd_wdata = 32'h0BADF00D;
    tick(); tick();
    chk("t3_slot0", 32'(owner), 32'd2);
    chk("t3_cpu_be", 32'(vram_be), 32'h8);
    chk("t3_cpu_wdata", vram_wdata, 32'hC3C3C3C3);
    repeat (4) tick();
    chk("t3_slot1", 32'(owner), 32'd3);
    chk("t3_cmd_be", 32'(vram_be), 32'h9);
    chk("t3_cmd_wdata", vram_wdata, 32'h0BADF00D);
    repeat (4) tick();
    chk("t3_slot2", 32'(owner), 32'd2);
    repeat (4) tick();
    chk("t3_slot3", 32'(owner), 32'd3);
    cpu_req = 1'b0; cmd_req = 1'b0;

    // Reset in phase 1 of a CPU slot abandons the access
    run_to(800);
    vdp_super = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 18'h01235;
    tick();
    chk("t6_granted", 32'(owner), 32'd2);
    reset = 1'b1;
    tick();
    chk("t6_owner", 32'(owner), 32'd0);
    chk("t6_addr", 32'(vram_addr), 32'd0);
    chk("t6_be", 32'(vram_be), 32'd0);
    chk("t6_wdata", vram_wdata, 32'd0);
    chk("t6_cpu_rdata", 32'(cpu_rdata), 32'd0);
    reset = 1'b0; cpu_req = 1'b0;
    tick();
    chk("t6_no_ack_a", 32'(cpu_ack), 32'd0);
    tick();
    chk("t6_no_ack_b", 32'(cpu_ack), 32'd0);

    for (int i = 0; i < 6000; i++) begin
      rand_drive();
      tick();
    end

    @(negedge clk);
    run = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
